// File: rtl/maxpool_row_sched.sv
// Row scheduler for the max-pool line cache: counts complete input rows as credits and
// sequences one output frame (top pad, SIZE data rows, bottom pad) with start delay and row gap.
module maxpool_row_sched #(
    parameter int WIDTH_C = 4,
    parameter int SIZE    = 14,
    parameter int CHANNEL = 256,
    parameter int GAP     = 0,
    parameter int PADWAIT = 21
) (
    input  logic               i_sclk,
    input  logic               i_rst,
    input  logic               i_vsync,
    input  logic               i_hsync,
    output logic               o_rdreq,
    output logic               o_vsync,
    output logic               o_hsync,
    output logic               o_reuse,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_err,
    output logic [2:0]         o_dbg_state,
    output logic [WIDTH_C-1:0] o_dbg_credit
);

    localparam int L      = SIZE * CHANNEL;
    localparam int BEAT_W = (L > 1) ? $clog2(L) : 1;
    localparam int ROW_W  = $clog2(SIZE + 1);

    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(L - 1);
    localparam logic [ROW_W-1:0]   ROWS      = ROW_W'(SIZE);
    localparam logic [7:0]         DLY_LAST  = 8'((PADWAIT > 0) ? PADWAIT - 1 : 0);
    localparam logic [7:0]         GAP_LAST  = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [WIDTH_C-1:0] CRED_MAX  = {WIDTH_C{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DLY  = 3'd1,
        PADT = 3'd2,
        GAPS = 3'd3,
        WAIT = 3'd4,
        DATA = 3'd5,
        PADB = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         dly_q, dly_d;
    logic [7:0]         gap_q, gap_d;
    logic [WIDTH_C-1:0] credit_q, credit_d;
    logic               err_q, err_d;
    logic               vsync_q, vsync_d;
    logic               hsync_q, hsync_d;
    logic               reuse_q, reuse_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic hs_in;
    logic credit_ok;
    logic row_end;
    logic advance;
    logic take;
    logic in_row;

    // A credit arriving this cycle may be spent this cycle, so WAIT->DATA costs no extra cycle.
    assign hs_in     = i_hsync && !i_vsync;
    assign credit_ok = (credit_q != '0) || hs_in;
    assign row_end   = (beat_q == BEAT_LAST);
    assign in_row    = (state_q == PADT) || (state_q == DATA) || (state_q == PADB);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        row_d   = row_q;
        dly_d   = dly_q;
        gap_d   = gap_q;
        advance = 1'b0;
        take    = 1'b0;

        if (in_row) begin
            beat_d = row_end ? '0 : beat_q + BEAT_W'(1);
        end

        case (state_q)
            DLY: begin
                if (dly_q == DLY_LAST) begin
                    dly_d   = '0;
                    state_d = PADT;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            PADT, DATA: begin
                if (row_end) begin
                    if (GAP != 0) state_d = GAPS;
                    else          advance = 1'b1;
                end
            end
            GAPS: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            WAIT:    advance = 1'b1;
            PADB:    if (row_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shared row-slot decision after a gap (or a row when there is no gap), and in WAIT.
        if (advance) begin
            if (row_q < ROWS) begin
                if (credit_ok) begin
                    state_d = DATA;
                    take    = 1'b1;
                    row_d   = row_q + ROW_W'(1);
                end else begin
                    state_d = WAIT;
                end
            end else begin
                state_d = PADB;
            end
        end

        if (i_vsync) begin
            state_d = DLY;
            beat_d  = '0;
            row_d   = '0;
            dly_d   = '0;
            gap_d   = '0;
            take    = 1'b0;
        end
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (i_vsync) begin
            credit_d = '0;
            err_d    = 1'b0;
        end else if (hs_in && !take) begin
            if (credit_q == CRED_MAX) err_d = 1'b1;
            else                      credit_d = credit_q + WIDTH_C'(1);
        end else if (take && !hs_in) begin
            credit_d = credit_q - WIDTH_C'(1);
        end
    end

    // Strobes are registered once to line up with the one-cycle FIFO read latency.
    always_comb begin
        vsync_d = (state_q == PADT) && (beat_q == '0);
        hsync_d = in_row && (beat_q == '0);
        valid_d = o_rdreq;
        reuse_d = o_rdreq && (row_q < ROWS);
        busy_d  = i_vsync || (state_q != IDLE);
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            row_q    <= '0;
            dly_q    <= '0;
            gap_q    <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            reuse_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            row_q    <= row_d;
            dly_q    <= dly_d;
            gap_q    <= gap_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            vsync_q  <= vsync_d;
            hsync_q  <= hsync_d;
            reuse_q  <= reuse_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign o_rdreq      = (state_q == DATA);
    assign o_vsync      = vsync_q;
    assign o_hsync      = hsync_q;
    assign o_reuse      = reuse_q;
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_dbg_state  = state_q;
    assign o_dbg_credit = credit_q;

endmodule

// File: tb/tb_maxpool_row_sched.sv
// Directed bench for maxpool_row_sched with SIZE=4, CHANNEL=2, GAP=1, PADWAIT=3 (L=8).
module tb_maxpool_row_sched;

    localparam int W = 128;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PADT = 3'd2;
    localparam logic [2:0] S_GAPS = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_PADB = 3'd6;

    logic       clk;
    logic       rst;
    logic       i_vsync;
    logic       i_hsync;
    logic       o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_busy, o_err;
    logic [2:0] o_dbg_state;
    logic [3:0] o_dbg_credit;

    int n_checks;
    int n_errors;

    logic [W-1:0] v_rdreq, v_vsync, v_hsync, v_reuse, v_valid, v_busy, v_err;
    logic [2:0]   st_a [W];
    logic [3:0]   cr_a [W];
    logic [7:0]   exp_q [$];

    maxpool_row_sched #(
        .WIDTH_C(4),
        .SIZE   (4),
        .CHANNEL(2),
        .GAP    (1),
        .PADWAIT(3)
    ) dut (
        .i_sclk      (clk),
        .i_rst       (rst),
        .i_vsync     (i_vsync),
        .i_hsync     (i_hsync),
        .o_rdreq     (o_rdreq),
        .o_vsync     (o_vsync),
        .o_hsync     (o_hsync),
        .o_reuse     (o_reuse),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_dbg_state (o_dbg_state),
        .o_dbg_credit(o_dbg_credit)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] m(input int lo, input int hi);
        logic [W-1:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] b(input int n);
        return m(n, n);
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs ncyc cycles from the current post-edge point; cycle 0 is the first cycle driven.
    task automatic run_window(input int ncyc, input logic [W-1:0] vs_in,
                              input logic [W-1:0] hs_in, input bit mon);
        v_rdreq = '0; v_vsync = '0; v_hsync = '0; v_reuse = '0;
        v_valid = '0; v_busy  = '0; v_err   = '0;
        for (int c = 0; c < ncyc; c++) begin
            v_rdreq[c] = o_rdreq;
            v_vsync[c] = o_vsync;
            v_hsync[c] = o_hsync;
            v_reuse[c] = o_reuse;
            v_valid[c] = o_valid;
            v_busy[c]  = o_busy;
            v_err[c]   = o_err;
            st_a[c]    = o_dbg_state;
            cr_a[c]    = o_dbg_credit;
            if (mon && o_hsync) begin
                if (exp_q.size() > 0) check("hsync_cycle", W'(c), W'(exp_q.pop_front()));
                else                  check("hsync_extra", W'(c), W'(W));
            end
            i_vsync = vs_in[c];
            i_hsync = hs_in[c];
            @(posedge clk);
            #1;
        end
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        if (mon) check("hsync_left", W'(exp_q.size()), '0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // reset state
        do_reset();
        check("reset_outputs", W'({o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_busy, o_err}), '0);
        check("reset_state", W'(o_dbg_state), W'(S_IDLE));
        check("reset_credit", W'(o_dbg_credit), '0);

        // credits preloaded
        exp_q = {8'd5, 8'd14, 8'd23, 8'd32, 8'd41, 8'd50};
        run_window(64, b(0), m(1, 4), 1'b1);
        check("pre_rdreq", v_rdreq, m(13, 20) | m(22, 29) | m(31, 38) | m(40, 47));
        check("pre_rdreq_beats", W'($countones(v_rdreq)), W'(32));
        check("pre_vsync", v_vsync, b(5));
        check("pre_hsync", v_hsync, b(5) | b(14) | b(23) | b(32) | b(41) | b(50));
        check("pre_valid", v_valid, m(14, 21) | m(23, 30) | m(32, 39) | m(41, 48));
        check("pre_reuse", v_reuse, m(14, 21) | m(23, 30) | m(32, 39));
        check("pre_busy", v_busy, m(1, 57));
        check("pre_err", v_err, '0);
        check("pre_st_padt", W'(st_a[4]), W'(S_PADT));
        check("pre_st_gaps", W'(st_a[12]), W'(S_GAPS));
        check("pre_st_padb", W'(st_a[49]), W'(S_PADB));
        check("pre_st_idle", W'(st_a[57]), W'(S_IDLE));
        check("pre_credit_end", W'(cr_a[63]), '0);

        // stall: third row credit only at cycle 40
        exp_q = {8'd5, 8'd14, 8'd23, 8'd42, 8'd51, 8'd60};
        run_window(80, b(0), m(1, 2) | b(40) | b(42), 1'b1);
        check("stall_rdreq", v_rdreq, m(13, 20) | m(22, 29) | m(41, 48) | m(50, 57));
        check("stall_rdreq_beats", W'($countones(v_rdreq)), W'(32));
        check("stall_st_wait31", W'(st_a[31]), W'(S_WAIT));
        check("stall_st_wait40", W'(st_a[40]), W'(S_WAIT));
        check("stall_st_data41", W'(st_a[41]), W'(S_DATA));
        check("stall_reuse", v_reuse, m(14, 21) | m(23, 30) | m(42, 49));
        check("stall_valid", v_valid, m(14, 21) | m(23, 30) | m(42, 49) | m(51, 58));
        check("stall_busy", v_busy, m(1, 67));

        // credit in and out in the same cycle
        run_window(40, b(0), b(1) | b(12), 1'b0);
        check("simul_credit12", W'(cr_a[12]), W'(1));
        check("simul_credit13", W'(cr_a[13]), W'(1));
        check("simul_credit22", W'(cr_a[22]), '0);
        check("simul_rdreq", v_rdreq, m(13, 20) | m(22, 29));
        check("simul_st_wait", W'(st_a[35]), W'(S_WAIT));

        // overflow: 16 credits with no reads, then vsync clears
        do_reset();
        run_window(24, b(20), m(0, 15), 1'b0);
        check("ovf_credit10", W'(cr_a[10]), W'(10));
        check("ovf_credit15", W'(cr_a[15]), W'(15));
        check("ovf_credit16", W'(cr_a[16]), W'(15));
        check("ovf_err", v_err, m(16, 20));
        check("ovf_credit_clear", W'(cr_a[21]), '0);

        // vsync mid-row (row 1, beat 3), with a dropped hsync alongside
        do_reset();
        run_window(40, b(0) | b(25), m(1, 4) | b(25), 1'b0);
        check("mid_rdreq", v_rdreq, m(13, 20) | m(22, 25));
        check("mid_credit25", W'(cr_a[25]), W'(2));
        check("mid_credit26", W'(cr_a[26]), '0);
        check("mid_vsync", v_vsync, b(5) | b(30));
        check("mid_busy", v_busy[39:1], {39{1'b1}});

        // asynchronous reset while a data row is in progress
        do_reset();
        run_window(17, b(0), m(1, 4), 1'b0);
        check("arst_pre_rdreq", W'(o_rdreq), W'(1));
        check("arst_pre_valid", W'(o_valid), W'(1));
        #3;
        rst = 1'b1;
        #1;
        check("arst_outputs", W'({o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_busy, o_err}), '0);
        check("arst_state", W'(o_dbg_state), W'(S_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_after_state", W'(o_dbg_state), W'(S_IDLE));
        check("arst_after_busy", W'(o_busy), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
